// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Data-memory responder behind the pipeline memory-stage port.
//            Word-addressed data RAM with per-byte-lane writes and an
//            asynchronous read, plus a 256-byte MMIO window holding an LED
//            register, a console TX FIFO (valid/ready drain), a free-running
//            cycle counter and a saturating dropped-write counter.
// Ports    : clk        - clock, all state updates on the rising edge
//            reset      - asynchronous active-low reset
//            addr       - byte address from the memory stage
//            wdata      - lane-aligned store data
//            we         - write enable
//            amp        - byte-lane enables, bit i gates wdata[8i+7:8i]
//            rdata      - raw read word, combinational from addr
//            led        - LED register
//            cons_valid - console FIFO head valid
//            cons_data  - console FIFO head byte
//            cons_ready - console sink accepts the head this cycle
// MMIO map : base+0x00 LED, +0x04 CONSOLE, +0x08 CYCLE, +0x0C DROPS
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic [3:0]  amp,
  output logic [31:0] rdata,
  output logic [15:0] led,
  output logic        cons_valid,
  output logic [7:0]  cons_data,
  input  logic        cons_ready
);

  localparam int c_ADDR_W = $clog2(DEPTH_WORDS);
  localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W  = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FIFO_DEPTH);

  // Word offsets (addr[7:2]) of the MMIO registers
  localparam logic [5:0] c_OFF_LED   = 6'd0;
  localparam logic [5:0] c_OFF_CONS  = 6'd1;
  localparam logic [5:0] c_OFF_CYCLE = 6'd2;
  localparam logic [5:0] c_OFF_DROPS = 6'd3;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0]        r_ram [DEPTH_WORDS];
  logic [7:0]         r_fifo [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_CNT_W-1:0] r_count;
  logic [15:0]        r_led;
  logic [31:0]        r_cycle;
  logic [7:0]         r_drops;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic                w_mmio_sel;
  logic [5:0]          w_offset;
  logic [c_ADDR_W-1:0] w_ram_idx;
  logic                w_ram_we;
  logic                w_mmio_we;
  logic [1:0]          w_unused_addr;

  assign w_mmio_sel    = (addr[31:8] == MMIO_BASE[31:8]);
  assign w_offset      = addr[7:2];
  // Upper address bits are dropped, so out-of-range addresses alias into RAM
  assign w_ram_idx     = addr[c_ADDR_W+1:2];
  assign w_ram_we      = we & ~w_mmio_sel;
  assign w_mmio_we     = we & w_mmio_sel;
  // Byte offset within a word plays no part in word selection
  assign w_unused_addr = addr[1:0];

  // --------------------------------------------------------------------------
  // Console FIFO control
  // --------------------------------------------------------------------------
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push_try;
  logic        w_push_ok;
  logic        w_drop;
  logic        w_drops_clr;
  logic [31:0] w_count_ext;
  logic [2:0]  w_count_field;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == c_FULL);
  assign w_pop       = ~w_empty & cons_ready;
  assign w_push_try  = w_mmio_we & (w_offset == c_OFF_CONS) & amp[0];
  // A full FIFO still takes a push when the head leaves in the same cycle
  assign w_push_ok   = w_push_try & (~w_full | w_pop);
  assign w_drop      = w_push_try & ~w_push_ok;
  assign w_drops_clr = w_mmio_we & (w_offset == c_OFF_DROPS);

  // Status count field is only 3 bits wide; deeper FIFOs report 7
  assign w_count_ext   = 32'(r_count);
  assign w_count_field = (w_count_ext > 32'd7) ? 3'd7 : w_count_ext[2:0];

  assign cons_valid = ~w_empty;
  // Gated so the head reads 0 after reset without clearing the storage
  assign cons_data  = w_empty ? 8'h00 : r_fifo[r_rptr];
  assign led        = r_led;

  // --------------------------------------------------------------------------
  // RAM: per-lane synchronous write, contents survive reset
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (amp[i]) begin
          r_ram[w_ram_idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // FIFO storage needs no reset: entries are only visible behind the count
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_fifo[r_wptr] <= wdata[7:0];
    end
  end

  // --------------------------------------------------------------------------
  // Registers with reset
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_led   <= 16'h0000;
      r_cycle <= 32'h0000_0000;
      r_drops <= 8'h00;
    end else begin
      r_cycle <= r_cycle + 32'd1;

      if (w_push_ok) begin
        r_wptr <= r_wptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_PTR_W'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase

      if (w_mmio_we && (w_offset == c_OFF_LED)) begin
        if (amp[0]) r_led[7:0]  <= wdata[7:0];
        if (amp[1]) r_led[15:8] <= wdata[15:8];
      end

      // Clear wins over a coincident drop
      if (w_drops_clr) begin
        r_drops <= 8'h00;
      end else if (w_drop && (r_drops != 8'hFF)) begin
        r_drops <= r_drops + 8'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------------
  always_comb begin
    rdata = 32'h0000_0000;
    if (w_mmio_sel) begin
      case (w_offset)
        c_OFF_LED:   rdata = {16'h0000, r_led};
        c_OFF_CONS:  rdata = {27'b0, w_count_field, w_empty, w_full};
        c_OFF_CYCLE: rdata = r_cycle;
        c_OFF_DROPS: rdata = {24'h000000, r_drops};
        default:     rdata = 32'h0000_0000;
      endcase
    end else begin
      rdata = r_ram[w_ram_idx];
    end
  end

endmodule
`default_nettype wire
